cache_state_array: RTL and testbench

Per-set, per-way valid/dirty state array for the set-associative data cache. It is the parametrised successor of the single-bit valid RAM: it adds multiple ways, a dirty bit per line, registered read of all ways of a set, and a sequential flush engine. The flush engine sweeps the array and either invalidates it or cleans and invalidates it, handing each dirty line to the write-back path over a valid/ready handshake. It sits beside the tag RAM; the cache controller owns the read/write ports and the flush request.

---
 rtl/cache_state_array_pkg.sv | 29 ++
 rtl/cache_state_array_flush_ctrl.sv | 132 +++++++++++++
 rtl/cache_state_array.sv | 106 ++++++++++
 tb/tb_cache_state_array.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_state_array_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the data-cache state array and its flush engine.
//   ABSENT / PRESENT     : encoding of a valid or dirty bit
//   CACHE_SETS/CACHE_WAYS: default geometry, shared with the tag RAM
//   flush_state_t        : flush engine states
//   way_width()          : width of a way number (at least one bit)
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam logic ABSENT  = 1'b0;
    localparam logic PRESENT = 1'b1;

    localparam int unsigned CACHE_SETS = 64;
    localparam int unsigned CACHE_WAYS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } flush_state_t;

    // A direct-mapped cache still carries a one-bit way field.
    function automatic int unsigned way_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_state_array_flush_ctrl.sv
// ----------------------------------------------------------------------------
// cache_flush_ctrl
// Sequential flush engine for the cache state array. Walks every set once,
// clearing it; in clean mode each valid+dirty line is first offered to the
// write-back path and the set is re-examined after every accepted offer.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   FlushReq, FlushMode   start request (IDLE only) and mode (1 = clean)
//   i_set_valid/dirty     valid/dirty vector of set o_ptr
//   o_ptr                 set currently being swept
//   o_clr_set             clear valid and dirty of every way in set o_ptr
//   o_clr_dirty           per-way dirty clear for set o_ptr
//   FlushBusy, FlushDone  engine active / one-cycle completion pulse
//   WbValid/Index/Way     line offered to write-back
//   WbReady               write-back accepts the offered line
// ----------------------------------------------------------------------------
module cache_flush_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = CACHE_SETS,
    parameter int unsigned WAYS  = CACHE_WAYS,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = way_width(WAYS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             FlushReq,
    input  logic             FlushMode,
    input  logic [WAYS-1:0]  i_set_valid,
    input  logic [WAYS-1:0]  i_set_dirty,
    output logic [IDX_W-1:0] o_ptr,
    output logic             o_clr_set,
    output logic [WAYS-1:0]  o_clr_dirty,
    output logic             FlushBusy,
    output logic             FlushDone,
    output logic             WbValid,
    output logic [IDX_W-1:0] WbIndex,
    output logic [WAY_W-1:0] WbWay,
    input  logic             WbReady
);

    flush_state_t     r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_mode, w_mode_nxt;
    logic [WAY_W-1:0] r_wb_way, w_wb_way_nxt;

    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;

    // Lowest-numbered valid+dirty way: scan downwards so the lowest match
    // is the last one written.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (i_set_valid[i-1] == PRESENT && i_set_dirty[i-1] == PRESENT) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i - 1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_mode   <= 1'b0;
            r_wb_way <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_mode   <= w_mode_nxt;
            r_wb_way <= w_wb_way_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_mode_nxt   = r_mode;
        w_wb_way_nxt = r_wb_way;
        o_clr_set    = 1'b0;
        o_clr_dirty  = '0;
        unique case (r_state)
            IDLE: begin
                if (FlushReq) begin
                    w_state_nxt = SCAN;
                    w_ptr_nxt   = '0;
                    w_mode_nxt  = FlushMode;
                end
            end
            SCAN: begin
                if (r_mode && w_hit) begin
                    w_state_nxt  = WB;
                    w_wb_way_nxt = w_hit_way;
                end else begin
                    o_clr_set = 1'b1;
                    // Terminate on the last index so ptr never wraps.
                    if (r_ptr == IDX_W'(SETS - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            WB: begin
                if (WbReady) begin
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        o_clr_dirty[w] = (r_wb_way == WAY_W'(w));
                    end
                    // Same ptr: the set is re-examined for further dirty ways.
                    w_state_nxt = SCAN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // All outputs decode flops only, so WbValid never depends on WbReady.
    assign o_ptr     = r_ptr;
    assign FlushBusy = (r_state != IDLE);
    assign FlushDone = (r_state == DONE);
    assign WbValid   = (r_state == WB);
    assign WbIndex   = r_ptr;
    assign WbWay     = r_wb_way;

endmodule

// File: rtl/cache_state_array.sv
// ----------------------------------------------------------------------------
// cache_state_array
// Per-set, per-way valid/dirty flop array for the set-associative data cache
// with a registered read of all ways of a set and a sequential flush engine.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset (clears all)
//   RdIndex               set to read; ValidOut/DirtyOut one cycle later
//   WrEn, WrIndex, WrWay  single-line write, dropped while FlushBusy=1
//   WrValid, WrDirty      new state of the written line
//   FlushReq, FlushMode   start flush (0 = invalidate, 1 = clean+invalidate)
//   FlushBusy, FlushDone  flush in progress / one-cycle completion pulse
//   WbValid, WbIndex,     dirty line offered to write-back during a clean
//   WbWay, WbReady        flush, valid/ready handshake
// ----------------------------------------------------------------------------
module cache_state_array
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = CACHE_SETS,
    parameter int unsigned WAYS  = CACHE_WAYS,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = way_width(WAYS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [IDX_W-1:0] RdIndex,
    output logic [WAYS-1:0]  ValidOut,
    output logic [WAYS-1:0]  DirtyOut,
    input  logic             WrEn,
    input  logic [IDX_W-1:0] WrIndex,
    input  logic [WAY_W-1:0] WrWay,
    input  logic             WrValid,
    input  logic             WrDirty,
    input  logic             FlushReq,
    input  logic             FlushMode,
    output logic             FlushBusy,
    output logic             FlushDone,
    output logic             WbValid,
    output logic [IDX_W-1:0] WbIndex,
    output logic [WAY_W-1:0] WbWay,
    input  logic             WbReady
);

    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAYS-1:0]  r_dirty [SETS];
    logic [WAYS-1:0]  r_valid_out;
    logic [WAYS-1:0]  r_dirty_out;

    logic [IDX_W-1:0] w_ptr;
    logic             w_clr_set;
    logic [WAYS-1:0]  w_clr_dirty;
    logic             w_busy;
    logic             w_wr_ok;

    cache_flush_ctrl #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_flush_ctrl (
        .Clk         (Clk),
        .Reset       (Reset),
        .FlushReq    (FlushReq),
        .FlushMode   (FlushMode),
        .i_set_valid (r_valid[w_ptr]),
        .i_set_dirty (r_dirty[w_ptr]),
        .o_ptr       (w_ptr),
        .o_clr_set   (w_clr_set),
        .o_clr_dirty (w_clr_dirty),
        .FlushBusy   (w_busy),
        .FlushDone   (FlushDone),
        .WbValid     (WbValid),
        .WbIndex     (WbIndex),
        .WbWay       (WbWay),
        .WbReady     (WbReady)
    );

    assign w_wr_ok = WrEn & ~w_busy;

    // Port writes and flush clears never coincide: ports are blocked while
    // the engine is busy, and the engine only clears while busy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid     <= '{default: {WAYS{ABSENT}}};
            r_dirty     <= '{default: {WAYS{ABSENT}}};
            r_valid_out <= {WAYS{ABSENT}};
            r_dirty_out <= {WAYS{ABSENT}};
        end else begin
            // Sampled before this edge's update: same-set read sees old data.
            r_valid_out <= r_valid[RdIndex];
            r_dirty_out <= r_dirty[RdIndex];
            if (w_wr_ok) begin
                r_valid[WrIndex][WrWay] <= WrValid;
                r_dirty[WrIndex][WrWay] <= WrDirty;
            end
            if (w_clr_set) begin
                r_valid[w_ptr] <= {WAYS{ABSENT}};
                r_dirty[w_ptr] <= {WAYS{ABSENT}};
            end else if (|w_clr_dirty) begin
                r_dirty[w_ptr] <= r_dirty[w_ptr] & ~w_clr_dirty;
            end
        end
    end

    assign ValidOut  = r_valid_out;
    assign DirtyOut  = r_dirty_out;
    assign FlushBusy = w_busy;

endmodule

// File: tb/tb_cache_state_array.sv
module tb_cache_state_array;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] RdIndex = '0;
    logic [1:0] ValidOut, DirtyOut;
    logic       WrEn = 1'b0;
    logic [5:0] WrIndex = '0;
    logic       WrWay = 1'b0;
    logic       WrValid = 1'b0;
    logic       WrDirty = 1'b0;
    logic       FlushReq = 1'b0;
    logic       FlushMode = 1'b0;
    logic       FlushBusy, FlushDone, WbValid;
    logic [5:0] WbIndex;
    logic       WbWay;
    logic       WbReady = 1'b0;

    cache_state_array #(
        .SETS (64),
        .WAYS (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RdIndex   (RdIndex),
        .ValidOut  (ValidOut),
        .DirtyOut  (DirtyOut),
        .WrEn      (WrEn),
        .WrIndex   (WrIndex),
        .WrWay     (WrWay),
        .WrValid   (WrValid),
        .WrDirty   (WrDirty),
        .FlushReq  (FlushReq),
        .FlushMode (FlushMode),
        .FlushBusy (FlushBusy),
        .FlushDone (FlushDone),
        .WbValid   (WbValid),
        .WbIndex   (WbIndex),
        .WbWay     (WbWay),
        .WbReady   (WbReady)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Expected-response queues (filled by stimulus, drained by the monitor).
    logic [3:0] rd_q[$];        // {ValidOut, DirtyOut}
    logic [9:0] st_exp_q[$];    // {busy, done, wbvalid, wbindex[5:0], wbway}
    logic [9:0] st_mask_q[$];
    logic [6:0] wb_q[$];        // {index, way}

    logic rd_issue = 1'b0;
    logic st_issue = 1'b0;
    logic rd_pend  = 1'b0;
    int   done_seen = 0;

    localparam logic [9:0] M_ALL  = 10'h3FF;
    localparam logic [9:0] M_CTRL = 10'b1110000000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic       pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [5:0] pidx = '0;
    logic       pway = 1'b0;
    logic [3:0] m_rd;
    logic [9:0] m_st, m_mask;
    logic [6:0] m_wb;

    always @(posedge Clk) rd_pend <= rd_issue;

    always @(negedge Clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) chk("rd_underflow", 1, 0);
            else begin
                m_rd = rd_q.pop_front();
                chk("read", {28'd0, ValidOut, DirtyOut}, {28'd0, m_rd});
            end
        end
        if (st_issue) begin
            if (st_exp_q.size() == 0) chk("st_underflow", 1, 0);
            else begin
                m_st   = st_exp_q.pop_front();
                m_mask = st_mask_q.pop_front();
                chk("status", {22'd0, {FlushBusy, FlushDone, WbValid, WbIndex, WbWay} & m_mask},
                    {22'd0, m_st & m_mask});
            end
        end
        if (WbValid && WbReady) begin
            if (wb_q.size() == 0) chk("wb_unexpected", {25'd0, WbIndex, WbWay}, 32'hFFFF_FFFF);
            else begin
                m_wb = wb_q.pop_front();
                chk("wb_offer", {25'd0, WbIndex, WbWay}, {25'd0, m_wb});
            end
        end
        if (pv && !pr && !prst)
            chk("wb_stable", {24'd0, WbValid, WbIndex, WbWay}, {24'd0, 1'b1, pidx, pway});
        if (FlushDone) done_seen++;
        pv   = WbValid;
        pr   = WbReady;
        prst = Reset;
        pidx = WbIndex;
        pway = WbWay;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge Clk);
        #1;
        WrEn     = 1'b0;
        FlushReq = 1'b0;
        rd_issue = 1'b0;
        st_issue = 1'b0;
    endtask

    task automatic issue_rd(input logic [5:0] s, input logic [3:0] e);
        RdIndex  = s;
        rd_q.push_back(e);
        rd_issue = 1'b1;
    endtask

    task automatic issue_st(input logic [9:0] e, input logic [9:0] m);
        st_exp_q.push_back(e);
        st_mask_q.push_back(m);
        st_issue = 1'b1;
    endtask

    task automatic wr(input logic [5:0] s, input logic w, input logic v, input logic d);
        WrEn    = 1'b1;
        WrIndex = s;
        WrWay   = w;
        WrValid = v;
        WrDirty = d;
    endtask

    task automatic read_all(input logic [3:0] e);
        for (int s = 0; s < 64; s++) begin
            step();
            issue_rd(6'(s), e);
        end
        step();
        step();
    endtask

    int d0, cyc, hold, dcyc, n;

    initial begin
        // ---- reset ----
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        issue_st(10'd0, M_ALL);
        issue_rd(6'd5, 4'b0000);

        // ---- single write, read, same-cycle read/write ----
        step();
        wr(6'd5, 1'b1, 1'b1, 1'b1);
        step();
        issue_rd(6'd5, 4'b1010);
        wr(6'd5, 1'b0, 1'b1, 1'b0);
        step();
        issue_rd(6'd5, 4'b1110);
        step();

        // ---- fill valid/clean, invalidate-only flush ----
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 2; w++) begin
                step();
                wr(6'(s), 1'(w), 1'b1, 1'b0);
            end
        end
        step(); issue_rd(6'd0, 4'b1100);
        step(); issue_rd(6'd5, 4'b1100);
        step(); issue_rd(6'd63, 4'b1100);
        step();
        step();
        d0 = done_seen;
        FlushReq  = 1'b1;
        FlushMode = 1'b0;
        issue_st(10'd0, M_CTRL);
        for (int c = 1; c <= 67; c++) begin
            step();
            issue_st({(c <= 65), (c == 65), 1'b0, 7'd0}, M_CTRL);
            if (c == 10) FlushReq = 1'b1;
            if (c == 20) wr(6'd8, 1'b0, 1'b1, 1'b1);
            if (c == 65) wr(6'd9, 1'b1, 1'b1, 1'b1);
        end
        step();
        chk("inv_done_count", done_seen - d0, 1);
        read_all(4'b0000);

        // ---- clean flush ----
        step(); wr(6'd3, 1'b0, 1'b1, 1'b1);
        step(); wr(6'd3, 1'b1, 1'b1, 1'b1);
        step(); wr(6'd63, 1'b1, 1'b1, 1'b1);
        step(); wr(6'd10, 1'b0, 1'b1, 1'b0);
        wb_q.push_back({6'd3, 1'b0});
        wb_q.push_back({6'd3, 1'b1});
        wb_q.push_back({6'd63, 1'b1});
        step();
        d0 = done_seen;
        FlushReq  = 1'b1;
        FlushMode = 1'b1;
        WbReady   = 1'b0;
        cyc  = 0;
        hold = 0;
        dcyc = 0;
        n    = 0;
        while (cyc < 400 && dcyc == 0) begin
            step();
            cyc++;
            if (cyc == 5)  FlushReq = 1'b1;
            if (cyc == 7)  wr(6'd20, 1'b0, 1'b1, 1'b1);
            if (cyc == 40) wr(6'd3, 1'b0, 1'b1, 1'b1);
            if (WbValid && n == 0 && hold < 4) begin
                WbReady = 1'b0;
                hold++;
            end else begin
                WbReady = 1'b1;
            end
            if (WbValid && WbReady) n++;
            if (FlushDone) dcyc = cyc;
        end
        chk("clean_done_cycle", dcyc, 75);
        WbReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            issue_st(10'd0, M_CTRL);
        end
        step();
        chk("clean_done_count", done_seen - d0, 1);
        chk("wb_all_offered", wb_q.size(), 0);
        read_all(4'b0000);

        // ---- reset while in WB ----
        step(); wr(6'd7, 1'b1, 1'b1, 1'b1);
        step();
        FlushReq  = 1'b1;
        FlushMode = 1'b1;
        WbReady   = 1'b0;
        n = 0;
        while (!WbValid && n < 200) begin
            step();
            n++;
        end
        chk("wb_reached", {31'd0, WbValid}, 1);
        issue_st({1'b1, 1'b0, 1'b1, 6'd7, 1'b1}, M_ALL);
        step();
        Reset = 1'b1;
        issue_st({1'b1, 1'b0, 1'b1, 6'd7, 1'b1}, M_ALL);
        step();
        Reset = 1'b0;
        d0 = done_seen;
        issue_st(10'd0, M_ALL);
        for (int c = 0; c < 5; c++) begin
            step();
            issue_st(10'd0, M_CTRL);
        end
        read_all(4'b0000);
        chk("reset_no_done", done_seen - d0, 0);

        step();
        chk("rd_q_drained", rd_q.size(), 0);
        chk("st_q_drained", st_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
